rf_port_arbiter: RTL
====================

Name: rf_port_arbiter

Overview:
- Shares one register file (1 write port, 2 read ports, M-bit addresses, N-bit data) between two requesters, e.g. the datapath sequencer (requester 0) and a debug/load unit (requester 1).
- Round-robin arbitration with a valid/ready handshake; at most one transaction issued per cycle.
- Drives the register file's write and read controls from registers.
- Returns read data with a requester tag at fixed latency.

Parameters:
- M, 3, register address width (2**M registers)
- N, 8, data width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset)
- req0_valid, req1_valid  in  1  transaction request
- req0_ready, req1_ready  out  1  grant; transaction accepted when valid&ready at rising edge
- req0_we, req1_we  in  1  transaction includes a write
- req0_waddr, req1_waddr  in  M  write address
- req0_wd, req1_wd  in  N  write data
- req0_re, req1_re  in  1  transaction includes a read of both ra and rb
- req0_ra, req1_ra  in  M  read address A
- req0_rb, req1_rb  in  M  read address B
- rf_wd  out  N  register-file write data
- rf_waddr  out  M  register-file write address
- rf_write  out  1  register-file write enable
- rf_ra  out  M  register-file read address A
- rf_reada  out  1  register-file read enable A
- rf_rb  out  M  register-file read address B
- rf_readb  out  1  register-file read enable B
- rf_qa  in  N  register-file read data A; valid the cycle after reada is high
- rf_qb  in  N  register-file read data B; valid the cycle after readb is high
- rsp_valid  out  1  read response valid, one-cycle pulse
- rsp_id  out  1  requester that issued the read
- rsp_qa  out  N  read data A
- rsp_qb  out  N  read data B

Behaviour:
- Reset (rst=0, async):
  - All rf_* outputs = 0.
  - rsp_valid = 0, rsp_id = 0, rsp_qa = 0, rsp_qb = 0.
  - Round-robin pointer = 0 (requester 0 preferred).
  - All in-flight transactions are discarded; no response is ever produced for them.
- Arbitration (combinational ready):
  - Only one requester valid: that requester gets ready.
  - Both valid: the pointer owner gets ready.
  - Neither valid: no ready.
  - ready is never asserted without the matching valid; at most one ready per cycle.
- Pointer update:
  - After each accepted transaction, the pointer moves to the other requester.
  - If nothing is accepted, the pointer holds.
- Requester rules: once valid is raised, the requester holds valid and all its fields stable until ready.
- Stage 1 (edge T, accept):
  - Register the request into rf_*: rf_write=we, rf_reada=rf_readb=re, plus addresses and data.
  - Store the id and re in the stage-2 tag.
  - With no accept, rf_write, rf_reada and rf_readb are 0 in the following cycle; addresses and data hold their last values.
- Stage 2: the register file samples rf_* at edge T+1. A write commits there; read data appears on rf_qa/rf_qb during cycle T+2.
- Response:
  - rsp_valid=1 during cycle T+2 for accepted transactions with re=1, with rsp_id = issuer.
  - rsp_qa/rsp_qb pass combinationally from rf_qa/rf_qb, or hold the forwarded value (see optional feature).
  - Write-only transactions produce no response.
- Throughput: one transaction per cycle, sustained. Back-to-back transactions pipeline without bubbles; responses return in issue order.
- A read issued in the cycle after a write to the same address sees the new value, because the write commits first.
- Same-transaction write and read to the same address: the read returns the old value (read-first), unless RF_FWD_EN is defined.
- A transaction with we=0 and re=0 is still accepted and consumes an arbitration turn; it has no effect.

Optional Feature:
- Macro: RF_FWD_EN.
- Defined: when a transaction has we=1, re=1 and waddr==ra (or waddr==rb), the matching rsp_qa (or rsp_qb) in cycle T+2 carries that transaction's wd (write-first). Needs an N-bit forward register and compare flags.
- Undefined: rsp_qa/rsp_qb always equal rf_qa/rf_qb (read-first).

Test Plan:
- Reset then write: rst=0 for 2 cycles, then rst=1; req0 writes 8'h05 to addr 3. Expect req0_ready=1 in the same cycle, rf_write=1 with waddr=3, wd=05 one cycle later, no response.
- Single read: req1 reads ra=3, rb=0 after the above. Expect rsp_valid=1 two cycles after accept, rsp_id=1, rsp_qa=05, rsp_qb = value held at addr 0.
- Contention: both valid continuously for 4 cycles. Expect grants 0,1,0,1. Each requester sees ready exactly twice; pointer=0 at the end.
- Back-to-back pipeline: req0 writes 8'hA1 to addr 2, then in the next cycle reads ra=2. Expect rsp_qa=A1 with no bubble between the two transactions.
- Same-address write+read: we=1, re=1, waddr=ra=4, wd=8'h3C, old value 8'h00. Expect rsp_qa=00 with RF_FWD_EN undefined, rsp_qa=3C with it defined.
- Reset mid-flight: rst=0 the cycle after a read is accepted. Expect no rsp_valid, all rf_* = 0 immediately, and req0 preferred after release.

Source files
------------

// File: rtl/rf_port_arbiter.sv
// -----------------------------------------------------------------------------
// rf_port_arbiter
//
// Shares one register file (1 write port, 2 read ports) between two
// requesters using round-robin arbitration with a valid/ready handshake.
// At most one transaction is issued per cycle. The register-file controls are
// driven from registers, and read data returns to the issuer with a tag two
// cycles after the accept.
//
// Optional build macro: RF_FWD_EN
//   undefined : read-first. A same-transaction write+read of one address
//               returns the old register contents.
//   defined   : write-first. The write data of that transaction is forwarded
//               onto rsp_qa / rsp_qb when the addresses match.
//
// Parameters
//   M : register address width (2**M registers)
//   N : data width
//
// Ports
//   clk, rst                 clock (rising edge), async active-low reset
//   reqX_valid / reqX_ready  request handshake for requester X (0 or 1)
//   reqX_we/waddr/wd         write part of the transaction
//   reqX_re/ra/rb            read part (re reads both ra and rb)
//   rf_write/waddr/wd        registered register-file write controls
//   rf_reada/ra, rf_readb/rb registered register-file read controls
//   rf_qa, rf_qb             register-file read data, valid the cycle after read
//   rsp_valid/id/qa/qb       read response: one-cycle pulse, issuer id, data
// -----------------------------------------------------------------------------
module rf_port_arbiter #(
    parameter int M = 3,
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,

    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic         req0_we,
    input  logic [M-1:0] req0_waddr,
    input  logic [N-1:0] req0_wd,
    input  logic         req0_re,
    input  logic [M-1:0] req0_ra,
    input  logic [M-1:0] req0_rb,

    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic         req1_we,
    input  logic [M-1:0] req1_waddr,
    input  logic [N-1:0] req1_wd,
    input  logic         req1_re,
    input  logic [M-1:0] req1_ra,
    input  logic [M-1:0] req1_rb,

    output logic [N-1:0] rf_wd,
    output logic [M-1:0] rf_waddr,
    output logic         rf_write,
    output logic [M-1:0] rf_ra,
    output logic         rf_reada,
    output logic [M-1:0] rf_rb,
    output logic         rf_readb,
    input  logic [N-1:0] rf_qa,
    input  logic [N-1:0] rf_qb,

    output logic         rsp_valid,
    output logic         rsp_id,
    output logic [N-1:0] rsp_qa,
    output logic [N-1:0] rsp_qb
);

    // Bit 0 of each pipe is the tag during the register-file access cycle,
    // bit STAGES is the tag during the response cycle.
    localparam int STAGES = 1;

    typedef struct packed {
        logic         we;
        logic [M-1:0] waddr;
        logic [N-1:0] wd;
        logic         re;
        logic [M-1:0] ra;
        logic [M-1:0] rb;
    } req_t;

    req_t req0, req1, sel;
    logic ptr;          // requester preferred when both are valid
    logic gnt0, gnt1, accept;

    logic [STAGES:0] vld_pipe;
    logic [STAGES:0] id_pipe;

    assign req0 = '{we: req0_we, waddr: req0_waddr, wd: req0_wd,
                    re: req0_re, ra: req0_ra, rb: req0_rb};
    assign req1 = '{we: req1_we, waddr: req1_waddr, wd: req1_wd,
                    re: req1_re, ra: req1_ra, rb: req1_rb};

    // ---------------------------------------------------------------- arbiter
    always_comb begin
        gnt0   = req0_valid & (~req1_valid | ~ptr);
        gnt1   = req1_valid & (~req0_valid |  ptr);
        accept = gnt0 | gnt1;
        sel    = gnt1 ? req1 : req0;
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;

    // The pointer hands preference to the requester that was not just served.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)        ptr <= 1'b0;
        else if (accept) ptr <= gnt0;
    end

    // ------------------------------------------------------ register-file drive
    // Enables are single-cycle; addresses and data hold when idle so the
    // register file sees quiet inputs between transactions.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rf_write <= 1'b0;
            rf_reada <= 1'b0;
            rf_readb <= 1'b0;
            rf_waddr <= '0;
            rf_wd    <= '0;
            rf_ra    <= '0;
            rf_rb    <= '0;
        end else begin
            rf_write <= accept & sel.we;
            rf_reada <= accept & sel.re;
            rf_readb <= accept & sel.re;
            if (accept) begin
                rf_waddr <= sel.waddr;
                rf_wd    <= sel.wd;
                rf_ra    <= sel.ra;
                rf_rb    <= sel.rb;
            end
        end
    end

    // ------------------------------------------------------------ response tag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_pipe <= '0;
            id_pipe  <= '0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:0], accept & sel.re};
            id_pipe  <= {id_pipe[STAGES-1:0],  gnt1};
        end
    end

    assign rsp_valid = vld_pipe[STAGES];
    assign rsp_id    = id_pipe[STAGES];

`ifdef RF_FWD_EN
    // Write-first: remember which read ports alias the same transaction's
    // write, and keep its data for the response cycle (rf_wd moves on once
    // the next transaction is accepted).
    logic [STAGES:0] fwd_a_pipe;
    logic [STAGES:0] fwd_b_pipe;
    logic [N-1:0]    fwd_wd;
    logic            hit_a, hit_b;

    always_comb begin
        hit_a = accept & sel.we & sel.re & (sel.waddr == sel.ra);
        hit_b = accept & sel.we & sel.re & (sel.waddr == sel.rb);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fwd_a_pipe <= '0;
            fwd_b_pipe <= '0;
            fwd_wd     <= '0;
        end else begin
            fwd_a_pipe <= {fwd_a_pipe[STAGES-1:0], hit_a};
            fwd_b_pipe <= {fwd_b_pipe[STAGES-1:0], hit_b};
            if (vld_pipe[0]) fwd_wd <= rf_wd;
        end
    end

    always_comb begin
        rsp_qa = '0;
        rsp_qb = '0;
        if (rsp_valid) begin
            rsp_qa = fwd_a_pipe[STAGES] ? fwd_wd : rf_qa;
            rsp_qb = fwd_b_pipe[STAGES] ? fwd_wd : rf_qb;
        end
    end
`else
    // Read-first: data comes straight from the register file. Gated by
    // rsp_valid so the response bus is quiet (and zero in reset) otherwise.
    always_comb begin
        rsp_qa = '0;
        rsp_qb = '0;
        if (rsp_valid) begin
            rsp_qa = rf_qa;
            rsp_qb = rf_qb;
        end
    end
`endif

endmodule
